// File: rtl/mod_updown_counter.sv
// Parameterised up/down counter with a prescaler, wrap or saturate at the
// limits, a one-cycle terminal-count pulse and sticky overflow/underflow flags.
module mod_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // Prescaler width; a 1-bit register is kept even when PRESCALE is 1 so
  // the datapath stays uniform (it then never leaves 0).
  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // A step happens on the last prescaler slot of an enabled cycle.
  logic step;
  assign step = en && (psc_q == PSC_LAST);

  // Next-state logic: clr beats load beats a count step; flag clear is
  // applied first so that a limit event on the same edge re-sets the flag.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    cnt_d = cnt_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;

    if (flag_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (clr) begin
      cnt_d = '0;
      psc_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
      psc_d = '0;
    end else if (en) begin
      if (!step) begin
        psc_d = psc_q + PW'(1);
      end else begin
        psc_d = '0;
        if (up) begin
          // >= rather than == keeps the count bounded even from a bad state.
          if (cnt_q >= MAX_W) begin
            cnt_d = SATURATE ? MAX_W : '0;
            ovf_d = 1'b1;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d = SATURATE ? '0 : MAX_W;
            unf_d = 1'b1;
            tc_d  = 1'b1;
          end else if (cnt_q > MAX_W) begin
            cnt_d = MAX_W;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q <= '0;
      psc_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: four differently parameterised
// instances, a directed vector table, hand-written corner sequences and a
// randomised run against a behavioural model.
module tb_mod_updown_counter;

  typedef struct packed {
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       up;
    logic       flag_clr;
  } drv_t;

  typedef struct {
    drv_t       in;
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    logic       unf;
  } vec_t;

  typedef struct {
    int cnt;
    int psc;
    bit tc;
    bit ovf;
    bit unf;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  drv_t a_in, b_in, c_in, d_in;

  logic [2:0] a_cnt;  logic a_tc, a_ovf, a_unf;
  logic [7:0] b_cnt;  logic b_tc, b_ovf, b_unf;
  logic [7:0] c_cnt;  logic c_tc, c_ovf, c_unf;
  logic [3:0] d_cnt;  logic d_tc, d_ovf, d_unf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // A: 3-bit full range, wrap, no prescale.
  mod_updown_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1'b0), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .clr(a_in.clr), .load(a_in.load), .load_val(a_in.load_val[2:0]),
    .en(a_in.en), .up(a_in.up), .flag_clr(a_in.flag_clr),
    .cnt(a_cnt), .tc(a_tc), .ovf(a_ovf), .unf(a_unf));

  // B: 8-bit, terminal 9, saturating.
  mod_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .clr(b_in.clr), .load(b_in.load), .load_val(b_in.load_val),
    .en(b_in.en), .up(b_in.up), .flag_clr(b_in.flag_clr),
    .cnt(b_cnt), .tc(b_tc), .ovf(b_ovf), .unf(b_unf));

  // C: 8-bit, terminal 9, wrapping.
  mod_updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1)) u_c (
    .clk(clk), .rst(rst), .clr(c_in.clr), .load(c_in.load), .load_val(c_in.load_val),
    .en(c_in.en), .up(c_in.up), .flag_clr(c_in.flag_clr),
    .cnt(c_cnt), .tc(c_tc), .ovf(c_ovf), .unf(c_unf));

  // D: 4-bit, terminal 11, wrapping, prescale by 4.
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(11), .SATURATE(1'b0), .PRESCALE(4)) u_d (
    .clk(clk), .rst(rst), .clr(d_in.clr), .load(d_in.load), .load_val(d_in.load_val[3:0]),
    .en(d_in.en), .up(d_in.up), .flag_clr(d_in.flag_clr),
    .cnt(d_cnt), .tc(d_tc), .ovf(d_ovf), .unf(d_unf));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic drv_t mk_in(bit clr, bit load, int lv, bit en, bit up, bit fc);
    drv_t d;
    d.clr = clr; d.load = load; d.load_val = 8'(lv);
    d.en = en; d.up = up; d.flag_clr = fc;
    return d;
  endfunction

  function automatic vec_t mk_vec(bit clr, bit load, int lv, bit en, bit up, bit fc,
                                  int cnt, bit tc, bit ovf, bit unf);
    vec_t v;
    v.in = mk_in(clr, load, lv, en, up, fc);
    v.cnt = 8'(cnt); v.tc = tc; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Behavioural reference: one clock edge of the counter.
  function automatic mstate_t model_step(input mstate_t s, input drv_t d, input int w,
                                         input int maxv, input bit sat, input int pre);
    mstate_t r;
    int lv;
    r = s;
    r.tc = 1'b0;
    lv = int'(d.load_val) % (1 << w);
    if (d.flag_clr) begin
      r.ovf = 1'b0;
      r.unf = 1'b0;
    end
    if (d.clr) begin
      r.cnt = 0;
      r.psc = 0;
    end else if (d.load) begin
      r.cnt = (lv > maxv) ? maxv : lv;
      r.psc = 0;
    end else if (d.en) begin
      r.psc = (s.psc + 1) % pre;
      if (r.psc == 0) begin
        if (d.up && s.cnt == maxv) begin
          r.cnt = sat ? maxv : 0;
          r.ovf = 1'b1;
          r.tc  = 1'b1;
        end else if (d.up) begin
          r.cnt = s.cnt + 1;
        end else if (s.cnt == 0) begin
          r.cnt = sat ? 0 : maxv;
          r.unf = 1'b1;
          r.tc  = 1'b1;
        end else begin
          r.cnt = s.cnt - 1;
        end
      end
    end
    return r;
  endfunction

  vec_t    vecs[16];
  mstate_t mb, md;

  initial begin
    vecs[0]  = mk_vec(0, 0,   0, 1, 0, 0, 9, 1, 0, 1); // underflow wraps to MAX
    vecs[1]  = mk_vec(0, 0,   0, 1, 0, 0, 8, 0, 0, 1);
    vecs[2]  = mk_vec(0, 0,   0, 1, 1, 0, 9, 0, 0, 1); // direction change
    vecs[3]  = mk_vec(0, 0,   0, 1, 1, 0, 0, 1, 1, 1); // overflow wraps to 0
    vecs[4]  = mk_vec(0, 0,   0, 0, 0, 1, 0, 0, 0, 0); // flag clear
    vecs[5]  = mk_vec(0, 0,   0, 1, 0, 1, 9, 1, 0, 1); // set beats flag clear
    vecs[6]  = mk_vec(0, 0,   0, 0, 0, 0, 9, 0, 0, 1);
    vecs[7]  = mk_vec(0, 1,   5, 1, 1, 0, 5, 0, 0, 1); // load beats step
    vecs[8]  = mk_vec(0, 0,   0, 1, 1, 0, 6, 0, 0, 1);
    vecs[9]  = mk_vec(1, 1,   7, 1, 1, 0, 0, 0, 0, 1); // clr beats load
    vecs[10] = mk_vec(0, 1, 255, 0, 0, 0, 9, 0, 0, 1); // load clamps to MAX
    vecs[11] = mk_vec(0, 0,   0, 1, 1, 0, 0, 1, 1, 1);
    vecs[12] = mk_vec(0, 0,   0, 0, 0, 0, 0, 0, 1, 1); // en=0 holds
    vecs[13] = mk_vec(0, 0,   0, 1, 1, 0, 1, 0, 1, 1);
    vecs[14] = mk_vec(0, 1,   9, 1, 1, 0, 9, 0, 1, 1); // load at MAX, no tc
    vecs[15] = mk_vec(1, 0,   0, 1, 1, 0, 0, 0, 1, 1); // clr at MAX, no tc

    a_in = '0; b_in = '0; c_in = '0; d_in = '0;

    // Reset held across edges: everything at zero.
    #12;
    check("rst_a_cnt", int'(a_cnt), 0);
    check("rst_b_cnt", int'(b_cnt), 0);
    check("rst_c_flags", int'({c_tc, c_ovf, c_unf}), 0);
    check("rst_d_cnt", int'(d_cnt), 0);
    rst = 1'b0;

    // Full-range wrap on A: 1..7 then 0 with tc and ovf.
    a_in = mk_in(0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("a_cnt_%0d", k), int'(a_cnt), k % 8);
      check($sformatf("a_tc_%0d", k), int'(a_tc), (k == 8) ? 1 : 0);
    end
    check("a_ovf", int'(a_ovf), 1);
    a_in = '0;
    tick();
    check("a_tc_drop", int'(a_tc), 0);

    // Saturating B: clamped load, down step, saturate at MAX.
    b_in = mk_in(0, 1, 200, 0, 0, 0); tick();
    check("b_load_clamp", int'(b_cnt), 9);
    b_in = mk_in(0, 0, 0, 1, 0, 0);   tick();
    check("b_down", int'(b_cnt), 8);
    b_in = mk_in(0, 1, 9, 0, 0, 0);   tick();
    check("b_load9", int'(b_cnt), 9);
    b_in = mk_in(0, 0, 0, 1, 1, 0);   tick();
    check("b_sat_cnt", int'(b_cnt), 9);
    check("b_sat_tc", int'(b_tc), 1);
    check("b_sat_ovf", int'(b_ovf), 1);
    b_in = '0;                        tick();
    check("b_tc_drop", int'(b_tc), 0);

    // Prescale on D: en 1,1,0,1,1 -> single step after the 4th enabled edge.
    begin
      bit en_pat[5] = '{1, 1, 0, 1, 1};
      int exp_cnt[5] = '{0, 0, 0, 0, 1};
      for (int k = 0; k < 5; k++) begin
        d_in = mk_in(0, 0, 0, en_pat[k], 1, 0);
        tick();
        check($sformatf("d_psc_%0d", k), int'(d_cnt), exp_cnt[k]);
      end
    end
    // Leave D two slots into its prescaler before the mid-run reset below.
    d_in = mk_in(0, 0, 0, 1, 1, 0); tick(); tick();
    check("d_mid_psc", int'(d_cnt), 1);
    d_in = '0;

    // Vector table on C.
    foreach (vecs[i]) begin
      c_in = vecs[i].in;
      tick();
      check($sformatf("vec%0d_cnt", i), int'(c_cnt), int'(vecs[i].cnt));
      check($sformatf("vec%0d_tc", i), int'(c_tc), int'(vecs[i].tc));
      check($sformatf("vec%0d_flags", i), int'({c_ovf, c_unf}), int'({vecs[i].ovf, vecs[i].unf}));
    end

    // Asynchronous reset at cnt=5, between edges.
    c_in = mk_in(0, 1, 5, 0, 0, 0); tick();
    c_in = '0;
    check("c_pre_rst", int'(c_cnt), 5);
    #2 rst = 1'b1;
    #1;
    check("c_async_rst_cnt", int'(c_cnt), 0);
    check("c_async_rst_flags", int'({c_tc, c_ovf, c_unf}), 0);
    check("d_async_rst_cnt", int'(d_cnt), 0);
    #1 rst = 1'b0;

    // After reset D needs a full four enabled cycles for its first step.
    d_in = mk_in(0, 0, 0, 1, 1, 0);
    tick(); tick(); tick();
    check("d_post_rst_3", int'(d_cnt), 0);
    tick();
    check("d_post_rst_4", int'(d_cnt), 1);
    d_in = '0;

    // Randomised run on B and D against the model, from a fresh reset.
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    mb = '{0, 0, 0, 0, 0};
    md = '{0, 0, 0, 0, 0};
    for (int n = 0; n < 10000; n++) begin
      b_in = mk_in($urandom_range(31) == 0, $urandom_range(15) == 0, $urandom_range(255),
                   $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(15) == 0);
      d_in = mk_in($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(255),
                   $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(15) == 0);
      tick();
      mb = model_step(mb, b_in, 8, 9, 1'b1, 1);
      md = model_step(md, d_in, 4, 11, 1'b0, 4);
      check("rand_b", int'({b_cnt, b_tc, b_ovf, b_unf}),
            (mb.cnt << 3) | (int'(mb.tc) << 2) | (int'(mb.ovf) << 1) | int'(mb.unf));
      check("rand_d", int'({d_cnt, d_tc, d_ovf, d_unf}),
            (md.cnt << 3) | (int'(md.tc) << 2) | (int'(md.ovf) << 1) | int'(md.unf));
      check("rand_b_bound", int'(b_cnt <= 8'd9), 1);
      check("rand_d_bound", int'(d_cnt <= 4'd11), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
